frame_buf_arbiter: RTL



---
 rtl/frame_buf_pkg.sv | 9 +
 rtl/fb_wr_fifo.sv | 54 +++++
 rtl/frame_buf_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/frame_buf_pkg.sv
// Shared constants for the camera/HDMI frame buffer arbiter.
// Write-FIFO entries are packed as {bank, pixel address, RGB pixel}.
package frame_buf_pkg;
   localparam int FRAME_PIXELS = 307200;
   localparam int ADDR_W       = 19;
   localparam int FIFO_AW      = 4;
   localparam int PIX_W        = 24;
   localparam int ENTRY_W      = 1 + ADDR_W + PIX_W;
endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous first-word-fall-through FIFO that queues camera writes.
// The head entry is visible on o_dout whenever o_empty is low.
module fb_wr_fifo
#(
   parameter int WIDTH = frame_buf_pkg::ENTRY_W,
   parameter int AW    = frame_buf_pkg::FIFO_AW
)(
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_count
);
   localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

   logic [WIDTH-1:0] r_mem [1 << AW];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_full    = (r_count == DEPTH);
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_dout    = r_mem[r_rd_ptr];
   assign w_push_ok = i_push & ~o_full;
   assign w_pop_ok  = i_pop & ~o_empty;

   // NOTE: the storage array has no reset; resetting the pointers is enough to discard it.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/frame_buf_arbiter.sv
// Shares one single-port frame memory between a camera writer and an HDMI reader.
// Two banks are double-buffered; display reads always win, camera writes queue.
module frame_buf_arbiter
   import frame_buf_pkg::*;
#(
   parameter int FRAME_PIXELS = frame_buf_pkg::FRAME_PIXELS,
   parameter int ADDR_W       = frame_buf_pkg::ADDR_W,
   parameter int FIFO_AW      = frame_buf_pkg::FIFO_AW
)(
   input  logic              clk,
   input  logic              rstn,
   input  logic              cam_frame_start,
   input  logic              cam_wr_valid,
   input  logic [PIX_W-1:0]  cam_wr_data,
   output logic              cam_wr_ready,
   input  logic              disp_vsync,
   input  logic              disp_rd,
   output logic [PIX_W-1:0]  disp_data,
   output logic              disp_bank,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W:0]   mem_addr,
   output logic [PIX_W-1:0]  mem_wdata,
   input  logic [PIX_W-1:0]  mem_rdata,
   output logic              ovf_sticky,
   output logic [15:0]       drop_cnt
);
   localparam int              EW       = 1 + ADDR_W + PIX_W;
   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_PIXELS - 1);
   localparam logic [FIFO_AW:0]  DEPTH    = (FIFO_AW+1)'(1 << FIFO_AW);

   logic              r_disp_bank, r_cam_bank, r_pending, r_wr_done, r_vsync_d;
   logic              r_ovf, r_rd_pend, r_mem_en, r_mem_we;
   logic [ADDR_W-1:0] r_wr_addr, r_rd_addr;
   logic [ADDR_W:0]   r_mem_addr;
   logic [PIX_W-1:0]  r_mem_wdata, r_disp_data;
   logic [15:0]       r_drop_cnt;

   logic              w_fifo_full, w_fifo_empty;
   logic [FIFO_AW:0]  w_fifo_count;
   logic [EW-1:0]     w_fifo_din, w_fifo_dout;
   logic              w_push, w_pop, w_vs_fall, w_swap, w_new_disp_bank, w_last_push;

   // Pixels arriving after the frame's last address, or alongside a frame start, are discarded.
   assign w_push          = cam_wr_valid & ~w_fifo_full & ~r_wr_done & ~cam_frame_start;
   assign w_last_push     = w_push & (r_wr_addr == LAST_PIX);
   assign w_pop           = ~disp_rd & ~w_fifo_empty;
   assign w_fifo_din      = {r_cam_bank, r_wr_addr, cam_wr_data};
   assign w_vs_fall       = r_vsync_d & ~disp_vsync;
   assign w_swap          = w_vs_fall & r_pending;
   assign w_new_disp_bank = r_disp_bank ^ w_swap;

   assign cam_wr_ready = (w_fifo_count != DEPTH);
   assign disp_data    = r_disp_data;
   assign disp_bank    = r_disp_bank;
   assign mem_en       = r_mem_en;
   assign mem_we       = r_mem_we;
   assign mem_addr     = r_mem_addr;
   assign mem_wdata    = r_mem_wdata;
   assign ovf_sticky   = r_ovf;
   assign drop_cnt     = r_drop_cnt;

   fb_wr_fifo #(.WIDTH(EW), .AW(FIFO_AW)) u_wr_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .i_push  (w_push),
      .i_din   (w_fifo_din),
      .i_pop   (w_pop),
      .o_dout  (w_fifo_dout),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_disp_bank <= 1'b0;
         r_cam_bank  <= 1'b1;
         r_pending   <= 1'b0;
         r_wr_done   <= 1'b0;
         r_vsync_d   <= 1'b0;
         r_ovf       <= 1'b0;
         r_wr_addr   <= '0;
         r_rd_addr   <= '0;
         r_drop_cnt  <= '0;
      end else begin
         r_vsync_d <= disp_vsync;
         if (w_swap) r_disp_bank <= ~r_disp_bank;

         if (w_vs_fall)   r_rd_addr <= '0;
         else if (disp_rd) r_rd_addr <= (r_rd_addr == LAST_PIX) ? '0 : r_rd_addr + 1'b1;

         // The swap is resolved first, so a coincident frame start targets the new back bank.
         if (cam_frame_start) begin
            r_wr_addr  <= '0;
            r_wr_done  <= 1'b0;
            r_cam_bank <= ~w_new_disp_bank;
            if (r_pending && !w_swap && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 1'b1;
         end else if (w_push) begin
            if (w_last_push) r_wr_done <= 1'b1;
            else             r_wr_addr <= r_wr_addr + 1'b1;
         end

         if (w_last_push)                  r_pending <= 1'b1;
         else if (cam_frame_start || w_swap) r_pending <= 1'b0;

         if (cam_wr_valid && w_fifo_full) r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_rd_pend   <= 1'b0;
         r_disp_data <= '0;
      end else begin
         r_mem_en <= disp_rd | ~w_fifo_empty;
         r_mem_we <= w_pop;
         if (disp_rd) begin
            r_mem_addr <= {r_disp_bank, r_rd_addr};
         end else if (!w_fifo_empty) begin
            r_mem_addr  <= w_fifo_dout[EW-1:PIX_W];
            r_mem_wdata <= w_fifo_dout[PIX_W-1:0];
         end
         r_rd_pend <= r_mem_en & ~r_mem_we;
         if (r_rd_pend) r_disp_data <= mem_rdata;
      end
   end
endmodule
